fb_rect_fill_ctrl: RTL and testbench



---
 rtl/fb_pkg.sv | 38 +++
 rtl/fb_xy_scanner.sv | 58 +++++
 rtl/fb_rect_fill_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fb_rect_fill_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fb_pkg
// Brief  : Shared frame-buffer constants, color codes, FSM state and command.
// Rev    : 1.0  initial release
// ============================================================================
package fb_pkg;

  localparam int FB_X_BITS = 11;
  localparam int FB_Y_BITS = 11;
  localparam int FB_HD     = 1280;
  localparam int FB_VD     = 1024;

  // Color codes are shared with the display path; do not renumber.
  typedef enum logic [1:0] {
    WHITE = 2'd0,
    BLACK = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CLIP = 2'd1;
  localparam state_t ST_FILL = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic [FB_X_BITS-1:0] x0;
    logic [FB_Y_BITS-1:0] y0;
    logic [FB_X_BITS-1:0] w;
    logic [FB_Y_BITS-1:0] h;
    color_e               color;
  } fb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/fb_xy_scanner.sv
`default_nettype none
// ============================================================================
// Module : fb_xy_scanner
// Brief  : Row-major 2D pixel counter with load, step and last-pixel flag.
// Rev    : 1.0  initial release
// ============================================================================
module fb_xy_scanner #(
  parameter int X_BITS = 11,
  parameter int Y_BITS = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [X_BITS-1:0] x0_i,
  input  logic [Y_BITS-1:0] y0_i,
  input  logic [X_BITS-1:0] x_end_i,
  input  logic [Y_BITS-1:0] y_end_i,
  input  logic              step_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o,
  output logic              last_o
);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic [X_BITS-1:0] r_x0;
  logic [X_BITS-1:0] r_x_end;
  logic [Y_BITS-1:0] r_y_end;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_x0    <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
    end else if (load_i) begin
      r_x     <= x0_i;
      r_y     <= y0_i;
      r_x0    <= x0_i;
      r_x_end <= x_end_i;
      r_y_end <= y_end_i;
    end else if (step_i) begin
      if (r_x < r_x_end) begin
        r_x <= r_x + 1'b1;
      end else begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end
    end
  end

  assign x_o    = r_x;
  assign y_o    = r_y;
  assign last_o = (r_x == r_x_end) && (r_y == r_y_end);

endmodule
`default_nettype wire

// File: rtl/fb_rect_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fb_rect_fill_ctrl
// Brief  : Clips a rectangle-fill command to the visible area and scans it
//          out as granted pixel writes, one per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module fb_rect_fill_ctrl
  import fb_pkg::*;
#(
  parameter int X_BITS     = FB_X_BITS,
  parameter int Y_BITS     = FB_Y_BITS,
  parameter int HD         = FB_HD,
  parameter int VD         = FB_VD,
  parameter int COLOR_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [X_BITS-1:0]     cmd_x0_i,
  input  logic [Y_BITS-1:0]     cmd_y0_i,
  input  logic [X_BITS-1:0]     cmd_w_i,
  input  logic [Y_BITS-1:0]     cmd_h_i,
  input  logic [COLOR_BITS-1:0] cmd_color_i,
  input  logic                  abort_i,
  input  logic                  wr_grant_i,
  output logic                  we_o,
  output logic [X_BITS-1:0]     addr_x_o,
  output logic [Y_BITS-1:0]     addr_y_o,
  output logic [COLOR_BITS-1:0] color_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [X_BITS:0] C_X_MAX = (X_BITS+1)'(HD - 1);
  localparam logic [Y_BITS:0] C_Y_MAX = (Y_BITS+1)'(VD - 1);
  localparam logic [X_BITS:0] C_X_LIM = (X_BITS+1)'(HD);
  localparam logic [Y_BITS:0] C_Y_LIM = (Y_BITS+1)'(VD);
  localparam logic [X_BITS:0] C_X_ONE = (X_BITS+1)'(1);
  localparam logic [Y_BITS:0] C_Y_ONE = (Y_BITS+1)'(1);

  state_t                r_state;
  logic                  r_ready;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;
  logic [COLOR_BITS-1:0] r_color_out;
  logic [X_BITS-1:0]     r_x0;
  logic [Y_BITS-1:0]     r_y0;
  logic [X_BITS-1:0]     r_w;
  logic [Y_BITS-1:0]     r_h;
  logic [COLOR_BITS-1:0] r_color;

  logic [X_BITS:0]       w_x_last_raw;
  logic [Y_BITS:0]       w_y_last_raw;
  logic [X_BITS-1:0]     w_x_end;
  logic [Y_BITS-1:0]     w_y_end;
  logic                  w_empty;
  logic                  w_load;
  logic                  w_consume;
  logic                  w_step;
  logic                  w_last;

  // One extra bit keeps x0+w-1 from wrapping before the clip compare.
  assign w_x_last_raw = {1'b0, r_x0} + {1'b0, r_w} - C_X_ONE;
  assign w_y_last_raw = {1'b0, r_y0} + {1'b0, r_h} - C_Y_ONE;

  assign w_x_end = (w_x_last_raw > C_X_MAX) ? C_X_MAX[X_BITS-1:0] : w_x_last_raw[X_BITS-1:0];
  assign w_y_end = (w_y_last_raw > C_Y_MAX) ? C_Y_MAX[Y_BITS-1:0] : w_y_last_raw[Y_BITS-1:0];

  assign w_empty = (r_w == '0) || (r_h == '0) ||
                   ({1'b0, r_x0} >= C_X_LIM) || ({1'b0, r_y0} >= C_Y_LIM);

  assign w_load    = (r_state == ST_CLIP) && !abort_i && !w_empty;
  assign w_consume = (r_state == ST_FILL) && r_we && wr_grant_i;
  assign w_step    = w_consume && !abort_i && !w_last;

  fb_xy_scanner #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_scanner (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_load),
    .x0_i    (r_x0),
    .y0_i    (r_y0),
    .x_end_i (w_x_end),
    .y_end_i (w_y_end),
    .step_i  (w_step),
    .x_o     (addr_x_o),
    .y_o     (addr_y_o),
    .last_o  (w_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_color_out <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_color     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i && r_ready) begin
            r_x0    <= cmd_x0_i;
            r_y0    <= cmd_y0_i;
            r_w     <= cmd_w_i;
            r_h     <= cmd_h_i;
            r_color <= cmd_color_i;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CLIP;
          end
        end
        ST_CLIP: begin
          if (abort_i || w_empty) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_we        <= 1'b1;
            r_color_out <= r_color;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          // A write granted on the abort edge still counts; nothing follows it.
          if (abort_i || (w_consume && w_last)) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign we_o        = r_we;
  assign color_o     = r_color_out;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fb_rect_fill_ctrl
// Brief  : Scoreboard bench for fb_rect_fill_ctrl with directed fill commands.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fb_rect_fill_ctrl;
  import fb_pkg::*;

  localparam int XB = 11;
  localparam int YB = 11;
  localparam int CB = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [XB-1:0] cmd_x0_i = '0;
  logic [YB-1:0] cmd_y0_i = '0;
  logic [XB-1:0] cmd_w_i = '0;
  logic [YB-1:0] cmd_h_i = '0;
  logic [CB-1:0] cmd_color_i = '0;
  logic          abort_i = 1'b0;
  logic          wr_grant_i = 1'b1;
  logic          we_o;
  logic [XB-1:0] addr_x_o;
  logic [YB-1:0] addr_y_o;
  logic [CB-1:0] color_o;
  logic          busy_o;
  logic          done_o;

  fb_rect_fill_ctrl #(
    .X_BITS(XB), .Y_BITS(YB), .HD(1280), .VD(1024), .COLOR_BITS(CB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_color_i(cmd_color_i), .abort_i(abort_i), .wr_grant_i(wr_grant_i),
    .we_o(we_o), .addr_x_o(addr_x_o), .addr_y_o(addr_y_o), .color_o(color_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  px_t exp_q[$];
  px_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;

  int stall_grant[5] = '{0, 0, 1, 0, 1};
  int stall_x[5]     = '{0, 0, 0, 1, 1};

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: every consumed write is popped from the scoreboard and compared.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt++;
      if (we_o && wr_grant_i) begin
        chk("wr_in_range", int'(addr_x_o < 11'd1280 && addr_y_o < 11'd1024), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_x", int'(addr_x_o), mon_e.x);
          chk("wr_y", int'(addr_y_o), mon_e.y);
          chk("wr_color", int'(color_o), mon_e.c);
        end
      end
    end
  end

  task automatic push_rect(input int x0, input int y0, input int x1, input int y1, input int c);
    px_t p;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        p.x = x; p.y = y; p.c = c;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic issue(input int x0, input int y0, input int w, input int h, input int c);
    cmd_x0_i    = x0[XB-1:0];
    cmd_y0_i    = y0[YB-1:0];
    cmd_w_i     = w[XB-1:0];
    cmd_h_i     = h[YB-1:0];
    cmd_color_i = c[CB-1:0];
    cmd_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_done_latency"}, lat, exp_lat);
  endtask

  task automatic end_test(input string nm, input int exp_done);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk({nm, "_done_pulses"}, done_cnt, exp_done);
    chk({nm, "_ready"}, int'(cmd_ready_o), 1);
    chk({nm, "_busy"}, int'(busy_o), 0);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
    done_cnt = 0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", int'(cmd_ready_o), 1);
    chk("rst_we", int'(we_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_addr_x", int'(addr_x_o), 0);
    chk("rst_addr_y", int'(addr_y_o), 0);
    chk("rst_color", int'(color_o), 0);
    @(posedge clk_i); #1;

    // Basic 3x2 fill in BLUE
    push_rect(10, 20, 12, 21, int'(BLUE));
    issue(10, 20, 3, 2, int'(BLUE));
    wait_done("basic", 8);
    end_test("basic", 1);

    // Clipped at the bottom-right corner
    push_rect(1278, 1022, 1279, 1023, int'(GREEN));
    issue(1278, 1022, 5, 5, int'(GREEN));
    wait_done("clip", 6);
    end_test("clip", 1);

    // Empty commands
    issue(5, 5, 0, 3, int'(BLACK));
    wait_done("empty_w0", 2);
    end_test("empty_w0", 1);
    issue(1280, 0, 4, 4, int'(BLACK));
    wait_done("empty_x_off", 2);
    end_test("empty_x_off", 1);

    // Grant stall: 2x1 at origin
    wr_grant_i = 1'b0;
    push_rect(0, 0, 1, 0, int'(WHITE));
    issue(0, 0, 2, 1, int'(WHITE));
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) begin
      wr_grant_i = stall_grant[i][0];
      @(negedge clk_i);
      chk("stall_we", int'(we_o), 1);
      chk("stall_addr_x", int'(addr_x_o), stall_x[i]);
      chk("stall_addr_y", int'(addr_y_o), 0);
      @(posedge clk_i); #1;
    end
    wr_grant_i = 1'b1;
    wait_done("stall", 1);
    end_test("stall", 1);

    // Abort on the edge of the third consumed write
    push_rect(100, 100, 102, 100, int'(BLUE));
    issue(100, 100, 4, 4, int'(BLUE));
    repeat (3) @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    wait_done("abort", 1);
    chk("abort_we_low", int'(we_o), 0);
    end_test("abort", 1);

    // Reset after five writes
    push_rect(0, 0, 3, 0, int'(BLACK));
    push_rect(0, 1, 0, 1, int'(BLACK));
    issue(0, 0, 4, 4, int'(BLACK));
    repeat (6) @(posedge clk_i);
    #1 rst_i = 1'b1;
    wr_grant_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("midrst_we", int'(we_o), 0);
    chk("midrst_ready", int'(cmd_ready_o), 1);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_done", int'(done_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    wr_grant_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_pending", exp_q.size(), 0);
    push_rect(0, 0, 0, 0, int'(GREEN));
    issue(0, 0, 1, 1, int'(GREEN));
    wait_done("after_rst", 3);
    end_test("after_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
